// File: rtl/max_pool2x2_pkg.sv
// max_pool2x2_pkg: shared CNN sizing constants for the conv1 -> pool1 boundary.
//   CNN_CONV1_OUT_W   : conv1 result width (pool1 input width)
//   CNN_POOL1_OUT_W   : pool1 output sample width
//   CNN_POOL1_IN_W/H  : pool1 input feature-map dimensions
//   CNN_POOL1_OUT_DIM : pool1 output feature-map dimension (square)
package max_pool2x2_pkg;
    localparam int CNN_CONV1_OUT_W   = 32;
    localparam int CNN_POOL1_OUT_W   = 16;
    localparam int CNN_POOL1_IN_W    = 24;
    localparam int CNN_POOL1_IN_H    = 24;
    localparam int CNN_POOL1_OUT_DIM = 12;
endpackage

// File: rtl/pool_linebuf.sv
// pool_linebuf: simple dual-port register array, synchronous write, combinational read.
//   clk   : write clock
//   w_en  : write enable
//   waddr : write address
//   din   : write data
//   raddr : read address
//   dout  : read data (combinational)
module pool_linebuf
    import max_pool2x2_pkg::*;
#(
    parameter int DEPTH = CNN_POOL1_OUT_DIM,
    parameter int WIDTH = CNN_CONV1_OUT_W,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             w_en,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] din,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (w_en) mem[waddr] <= din;

    assign dout = mem[raddr];
endmodule

// File: rtl/max_pool2x2.sv
// max_pool2x2: 2x2 stride-2 unsigned max-pooling of a valid-qualified raster stream.
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   data_in        : DATA_W-bit unsigned input sample
//   data_in_valid  : data_in accepted on this edge
//   data_out       : OUT_W-bit pooled sample
//   data_out_valid : one-cycle pulse per pooled sample
//   frame_done     : pulse coincident with the last pooled sample of a frame
// Build option: define POOL_SAT_EN to saturate (instead of truncate) to OUT_W bits.
module max_pool2x2
    import max_pool2x2_pkg::*;
#(
    parameter int DATA_W = CNN_CONV1_OUT_W,
    parameter int OUT_W  = CNN_POOL1_OUT_W,
    parameter int IN_W   = CNN_POOL1_IN_W,
    parameter int IN_H   = CNN_POOL1_IN_H
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_valid,
    output logic [OUT_W-1:0]  data_out,
    output logic              data_out_valid,
    output logic              frame_done
);
    localparam int CW = $clog2(IN_W);
    localparam int RW = $clog2(IN_H);
    localparam int AW = (CW > 1) ? CW - 1 : 1;

    logic [CW-1:0]     col_cnt;
    logic [RW-1:0]     row_cnt;
    logic [DATA_W-1:0] hold_reg, hmax, pmax, lb_dout;
    logic [OUT_W-1:0]  pmax_fmt;
    logic [AW-1:0]     lb_addr;
    logic              last_col, last_row, lb_wen;

    assign last_col = col_cnt == CW'(IN_W - 1);
    assign last_row = row_cnt == RW'(IN_H - 1);
    assign lb_addr  = AW'(col_cnt >> 1);
    assign hmax     = (data_in > hold_reg) ? data_in : hold_reg;
    assign pmax     = (lb_dout > hmax) ? lb_dout : hmax;
    // Top row of a window parks its pair maximum; bottom row reads it back.
    assign lb_wen   = data_in_valid & col_cnt[0] & ~row_cnt[0];

`ifdef POOL_SAT_EN
    localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'({OUT_W{1'b1}});
    assign pmax_fmt = (pmax > SAT_MAX) ? {OUT_W{1'b1}} : OUT_W'(pmax);
`else
    assign pmax_fmt = OUT_W'(pmax);
`endif

    pool_linebuf #(.DEPTH(IN_W / 2), .WIDTH(DATA_W), .AW(AW)) u_linebuf (
        .clk   (clk),
        .w_en  (lb_wen),
        .waddr (lb_addr),
        .din   (hmax),
        .raddr (lb_addr),
        .dout  (lb_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt        <= '0;
            row_cnt        <= '0;
            hold_reg       <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            data_out_valid <= 1'b0;
            frame_done     <= 1'b0;
            if (data_in_valid) begin
                col_cnt <= last_col ? '0 : col_cnt + 1'b1;
                if (last_col) row_cnt <= last_row ? '0 : row_cnt + 1'b1;
                if (!col_cnt[0]) begin
                    hold_reg <= data_in;
                end else if (row_cnt[0]) begin
                    data_out       <= pmax_fmt;
                    data_out_valid <= 1'b1;
                    frame_done     <= last_col & last_row;
                end
            end
        end
    end
endmodule

// File: tb/tb_max_pool2x2.sv
// tb_max_pool2x2: directed self-checking bench for max_pool2x2 (honours POOL_SAT_EN).
module tb_max_pool2x2;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] data_in = '0;
    logic        data_in_valid = 1'b0;
    logic [15:0] data_out;
    logic        data_out_valid, frame_done;
    int          checks = 0, errors = 0, n_out = 0;
    int          fd_at[$];

`ifdef POOL_SAT_EN
    localparam logic [15:0] WIDE_EXP = 16'hFFFF;
`else
    localparam logic [15:0] WIDE_EXP = 16'h2345;
`endif

    always #5 clk = ~clk;

    max_pool2x2 dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .frame_done     (frame_done)
    );

    // mode 0: ramp, 1: max rotates through window positions, 2: one wide value
    function automatic logic [31:0] pix(input int mode, input int r, input int c);
        case (mode)
            0:       return 32'(r * 24 + c);
            1:       return (((r % 2) * 2 + (c % 2)) == (((r / 2) * 12 + c / 2) % 4)) ? 32'd1000 : 32'd0;
            default: return (r == 4 && c == 7) ? 32'h0001_2345 : 32'd0;
        endcase
    endfunction

    function automatic logic [15:0] pexp(input int mode, input int pr, input int pc);
        case (mode)
            0:       return 16'((2 * pr + 1) * 24 + 2 * pc + 1);
            1:       return 16'd1000;
            default: return (pr == 2 && pc == 3) ? WIDE_EXP : 16'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input int mode, input int r, input int c, input bit gap);
        if (gap)
            while ($urandom_range(0, 99) >= 30) begin
                data_in_valid = 1'b0;
                @(posedge clk); #1;
                check($sformatf("idle_v r%0d c%0d", r, c), 32'(data_out_valid), 0);
                check($sformatf("idle_fd r%0d c%0d", r, c), 32'(frame_done), 0);
            end
        data_in = pix(mode, r, c);
        data_in_valid = 1'b1;
        @(posedge clk); #1;
        if (r % 2 == 1 && c % 2 == 1) begin
            check($sformatf("m%0d v r%0d c%0d", mode, r, c), 32'(data_out_valid), 1);
            check($sformatf("m%0d d r%0d c%0d", mode, r, c), 32'(data_out), 32'(pexp(mode, r / 2, c / 2)));
            check($sformatf("m%0d fd r%0d c%0d", mode, r, c), 32'(frame_done), 32'(r == 23 && c == 23));
        end else begin
            check($sformatf("m%0d v r%0d c%0d", mode, r, c), 32'(data_out_valid), 0);
            check($sformatf("m%0d fd r%0d c%0d", mode, r, c), 32'(frame_done), 0);
        end
        n_out += int'(data_out_valid);
        if (frame_done) fd_at.push_back(n_out);
    endtask

    task automatic frame(input int mode, input bit gap, input int nbeats);
        for (int i = 0; i < nbeats; i++) beat(mode, i / 24, i % 24, gap);
    endtask

    task automatic idle_check(input string tag);
        data_in_valid = 1'b0;
        @(posedge clk); #1;
        check({tag, "_v"}, 32'(data_out_valid), 0);
        check({tag, "_fd"}, 32'(frame_done), 0);
    endtask

    initial begin
        #12;
        check("rst_d", 32'(data_out), 0);
        check("rst_v", 32'(data_out_valid), 0);
        check("rst_fd", 32'(frame_done), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        frame(0, 1'b0, 576);
        check("ramp_count", n_out, 144);
        check("ramp_fd_count", fd_at.size(), 1);
        idle_check("after_ramp");

        frame(1, 1'b0, 576);
        idle_check("after_rot");

        n_out = 0;
        frame(0, 1'b1, 576);
        check("gap_count", n_out, 144);
        idle_check("after_gap");

        frame(2, 1'b0, 576);
        idle_check("after_wide");

        frame(0, 1'b0, 300);
        data_in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_d", 32'(data_out), 0);
        check("mid_rst_v", 32'(data_out_valid), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_out = 0;
        frame(0, 1'b0, 576);
        check("post_rst_count", n_out, 144);

        n_out = 0;
        fd_at.delete();
        frame(0, 1'b0, 576);
        frame(0, 1'b0, 576);
        check("b2b_count", n_out, 288);
        check("b2b_fd_count", fd_at.size(), 2);
        if (fd_at.size() == 2) begin
            check("b2b_fd_first", fd_at[0], 144);
            check("b2b_fd_spacing", fd_at[1] - fd_at[0], 144);
        end
        idle_check("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/max_pool2x2.md
Name: max_pool2x2

Overview:
- 2x2, stride-2 max-pooling stage that sits directly downstream of the first convolution stage.
- Consumes that stage's valid-qualified stream: one 24x24 feature map of non-negative 32-bit results, raster order, gaps between valid beats allowed.
- Emits a 12x12 pooled map in raster order, feeding the next convolution stage.
- Holds one half-width row of horizontal pair maxima in a small line buffer.

Parameters:
- DATA_W, 32, input sample width; unsigned (upstream clamps negatives to 0).
- OUT_W, 16, output sample width; must be <= DATA_W.
- IN_W, 24, valid samples per input row; must be even.
- IN_H, 24, valid rows per input frame; must be even.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  DATA_W  input sample from the convolution stage.
- data_in_valid  in  1  data_in is consumed on this edge.
- data_out  out  OUT_W  pooled sample.
- data_out_valid  out  1  data_out valid, one-cycle pulse per pooled sample.
- frame_done  out  1  one-cycle pulse coincident with the last (144th) data_out_valid of a frame.

Behaviour:
- Reset is asynchronous, active-low. Under reset: col_cnt=0, row_cnt=0, hold_reg=0, data_out=0, data_out_valid=0, frame_done=0.
- The line buffer is not reset. It is always written before it is read within a frame.
- Only edges with data_in_valid=1 advance state. Idle cycles hold all state; data_out_valid and frame_done drop to 0.
- col_cnt runs 0..IN_W-1 and wraps to 0. On wrap, row_cnt increments; row_cnt runs 0..IN_H-1 and wraps to 0 (next frame).
- Even col (col_cnt[0]=0): hold_reg <= data_in.
- Odd col: hmax = max(hold_reg, data_in), unsigned compare; ties select either, value is identical.
  - Even row: linebuf[col_cnt>>1] <= hmax. No output.
  - Odd row: pmax = max(linebuf[col_cnt>>1], hmax). Registered output at the next edge: data_out <= fmt(pmax), data_out_valid <= 1.
- Latency: exactly 1 clk from the accepting edge of the bottom-right sample of each 2x2 window to data_out_valid=1.
- Throughput: at most one output every 2 accepted inputs. No backpressure; downstream must accept every pulse.
- frame_done=1 in the same cycle as data_out_valid when the output comes from row_cnt=IN_H-1, col_cnt=IN_W-1.
- fmt(): truncation to the low OUT_W bits by default (see Optional Feature).
- Line buffer: IN_W/2 entries x DATA_W, combinational read, synchronous write. Read and write never target the same row phase, so there is no read/write collision.
- Reset mid-frame: the counters restart at (0,0). The next accepted sample is treated as the top-left of a new frame. Partial windows are discarded and never output.
- Back-to-back frames: no idle cycle is required between the last sample of frame N and the first sample of frame N+1.

Optional Feature:
- Macro POOL_SAT_EN.
- Defined: fmt(pmax) = (pmax > 2^OUT_W-1) ? 2^OUT_W-1 : pmax[OUT_W-1:0], i.e. unsigned saturation.
- Undefined: plain truncation to pmax[OUT_W-1:0].
- Latency, valid timing and frame_done are identical in both builds. When OUT_W==DATA_W the two builds give identical results.

Decomposition:
- Shared defines file (alongside the existing CNN defines):
  - CNN_CONV1_OUT_W (32), CNN_POOL1_OUT_W (16).
  - CNN_POOL1_IN_W / CNN_POOL1_IN_H (24), CNN_POOL1_OUT_DIM (12).
- One sub-module: pool_linebuf. Simple dual-port register array, parameters DEPTH and WIDTH, ports clk, w_en, waddr, din, raddr, dout (combinational read).
- Counters, hmax/pmax comparators and output register live in max_pool2x2.

Test Plan:
- Ramp frame, data_in = row*24+col, continuous valid -> 144 outputs; output (r,c) = (2r+1)*24+2c+1, e.g. first output 25, last 575; frame_done only with the 575 output.
- Max location rotation: in each window, place 1000 at each of the 4 positions in turn, others 0 -> every output = 1000.
- Gapped valid: the same ramp frame with data_in_valid pseudo-random at 30% duty -> same 144 values in the same order; each data_out_valid exactly 1 cycle after its bottom-right accepting edge.
- Width boundary, OUT_W=16: input 0x0001_2345 in one window, rest 0 -> 0x2345 without POOL_SAT_EN; 0xFFFF with POOL_SAT_EN.
- Reset mid-frame: assert rst_n=0 after 300 samples, then send a full ramp frame -> outputs are exactly as in the first scenario, with no spurious output from pre-reset data.
- Two back-to-back frames with no idle cycle -> 288 outputs and two frame_done pulses, exactly 144 valid outputs apart.
